dircc_node_rx_msg_writer: RTL and testbench

Receive-side message writer for a DiRCC processing node. It accepts 16-bit message flits from the node's network input and writes them into the node processing memory through that memory's 16-bit second port (s2). Messages land in a ring of fixed-size slots, and the node's Nios CPU reads them over the 32-bit port. Occupancy is reported to the CPU; the CPU frees slots with a release pulse.

---
 rtl/dircc_node_rx_msg_writer_if.sv | 40 ++++
 rtl/dircc_node_rx_msg_writer.sv | 181 ++++++++++++++++++
 tb/tb_dircc_node_rx_msg_writer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dircc_node_rx_msg_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : dircc_node_rx_msg_writer_if
// Description : Flit input stream and 16-bit memory port (s2) of the DiRCC
//               receive message writer, bundled as one interface.
// Revision    : 1.0 - initial release
// ============================================================================
interface dircc_node_rx_msg_writer_if;
    // Flit stream from the network input
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_sop;
    logic        in_eop;

    // Processing-memory second port
    logic [13:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [15:0] mem_writedata;
    logic [1:0]  mem_byteenable;
    logic        mem_clken;

    // Environment side: drives flits, observes memory writes
    modport master (
        output in_valid, in_data, in_sop, in_eop,
        input  in_ready,
        input  mem_address, mem_chipselect, mem_write, mem_writedata,
        input  mem_byteenable, mem_clken
    );

    // Writer side: consumes flits, drives memory writes
    modport slave (
        input  in_valid, in_data, in_sop, in_eop,
        output in_ready,
        output mem_address, mem_chipselect, mem_write, mem_writedata,
        output mem_byteenable, mem_clken
    );
endinterface : dircc_node_rx_msg_writer_if
`default_nettype wire

// File: rtl/dircc_node_rx_msg_writer.sv
`default_nettype none
// ============================================================================
// Module      : dircc_node_rx_msg_writer
// Description : Writes incoming message flits into a ring of fixed-size slots
//               in node memory, prepends a {trunc, length} header per slot and
//               reports slot occupancy to the CPU.
//               Optional macro DIRCC_RX_DROP_COUNT_EN builds the saturating
//               dropped-message counter; otherwise drop_count reads 0.
// Revision    : 1.0 - initial release
// ============================================================================
module dircc_node_rx_msg_writer #(
    parameter logic [13:0] BASE_ADDR  = 14'h2000,
    parameter int          SLOT_WORDS = 32,
    parameter int          NUM_SLOTS  = 8
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    dircc_node_rx_msg_writer_if.slave  bus,
    input  wire logic                  slot_release,
    output logic [4:0]                 slots_used,
    output logic                       irq,
    output logic [15:0]                drop_count
);

    localparam int          SLOT_BITS  = $clog2(NUM_SLOTS);
    localparam logic [14:0] LAST_OFF   = 15'(SLOT_WORDS - 1);
    localparam logic [5:0]  FULL_COUNT = 6'(NUM_SLOTS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_HEADER  = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    state_t                 r_state, w_state_n;
    logic [SLOT_BITS-1:0]   r_wr_slot;
    logic [14:0]            r_length, w_length_n;
    logic                   r_trunc, w_trunc_n;
    logic [4:0]             r_slots_used;
    logic                   r_commit_pend;
    logic                   w_accept;
    logic                   w_ring_full;
    logic                   w_release;
    logic [13:0]            w_slot_base;
    logic                   w_wr_en;
    logic [13:0]            w_wr_addr;
    logic [15:0]            w_wr_data;
    logic                   w_commit;

    assign bus.in_ready       = !reset && (r_state != ST_HEADER);
    assign bus.mem_byteenable = 2'b11;
    assign bus.mem_clken      = 1'b1;

    assign w_accept    = bus.in_valid && bus.in_ready;
    assign w_slot_base = BASE_ADDR + (14'(r_wr_slot) * 14'(SLOT_WORDS));
    // A header latched last cycle is not counted yet but already owns its slot
    assign w_ring_full = ({1'b0, r_slots_used} + {5'b0, r_commit_pend}) >= FULL_COUNT;
    assign w_release   = slot_release && (r_slots_used != 5'd0);

    assign slots_used  = r_slots_used;
    assign irq         = (r_slots_used != 5'd0);

    // Next-state, length/trunc tracking and the memory write request
    always_comb begin
        w_state_n  = r_state;
        w_length_n = r_length;
        w_trunc_n  = r_trunc;
        w_wr_en    = 1'b0;
        w_wr_addr  = w_slot_base;
        w_wr_data  = bus.in_data;
        w_commit   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && bus.in_sop) begin
                    if (w_ring_full) begin
                        if (!bus.in_eop) w_state_n = ST_DROP;
                    end else begin
                        w_wr_en    = 1'b1;
                        w_wr_addr  = w_slot_base + 14'd1;
                        w_length_n = 15'd1;
                        w_trunc_n  = 1'b0;
                        w_state_n  = bus.in_eop ? ST_HEADER : ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_accept) begin
                    if (r_length != 15'h7FFF) w_length_n = r_length + 15'd1;
                    // Flit k of the message lands at offset k while it fits
                    if (r_length < LAST_OFF) begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = w_slot_base + 14'(r_length) + 14'd1;
                    end else begin
                        w_trunc_n = 1'b1;
                    end
                    if (bus.in_eop) w_state_n = ST_HEADER;
                end
            end
            ST_HEADER: begin
                w_wr_en   = 1'b1;
                w_wr_addr = w_slot_base;
                w_wr_data = {r_trunc, r_length};
                w_commit  = 1'b1;
                w_state_n = ST_IDLE;
            end
            ST_DROP: begin
                if (w_accept && bus.in_eop) w_state_n = ST_IDLE;
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // State, slot pointer and message bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_wr_slot     <= '0;
            r_length      <= 15'd0;
            r_trunc       <= 1'b0;
            r_commit_pend <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_length      <= w_length_n;
            r_trunc       <= w_trunc_n;
            r_commit_pend <= w_commit;
            if (w_commit) r_wr_slot <= r_wr_slot + 1'b1;
        end
    end

    // Occupancy moves on the edge the RAM captures the header
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slots_used <= 5'd0;
        end else begin
            case ({r_commit_pend, w_release})
                2'b10:   r_slots_used <= r_slots_used + 5'd1;
                2'b01:   r_slots_used <= r_slots_used - 5'd1;
                default: r_slots_used <= r_slots_used;
            endcase
        end
    end

    // Registered s2 write port; strobes last exactly one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_chipselect <= 1'b0;
            bus.mem_write      <= 1'b0;
            bus.mem_address    <= 14'd0;
            bus.mem_writedata  <= 16'd0;
        end else begin
            bus.mem_chipselect <= w_wr_en;
            bus.mem_write      <= w_wr_en;
            if (w_wr_en) begin
                bus.mem_address   <= w_wr_addr;
                bus.mem_writedata <= w_wr_data;
            end
        end
    end

`ifdef DIRCC_RX_DROP_COUNT_EN
    logic        w_drop;
    logic [15:0] r_drop_count;

    assign w_drop     = (r_state == ST_IDLE) && w_accept && bus.in_sop && w_ring_full;
    assign drop_count = r_drop_count;

    // Saturating count of messages refused because the ring was full
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_count <= 16'd0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end
`else
    assign drop_count = 16'h0000;
`endif

endmodule : dircc_node_rx_msg_writer
`default_nettype wire

// File: tb/tb_dircc_node_rx_msg_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dircc_node_rx_msg_writer
// Description : Directed self-checking bench for dircc_node_rx_msg_writer
//               (BASE_ADDR 14'h2000, SLOT_WORDS 16, NUM_SLOTS 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dircc_node_rx_msg_writer;

`ifdef DIRCC_RX_DROP_COUNT_EN
    localparam int DC_EN = 1;
`else
    localparam int DC_EN = 0;
`endif

    logic        clk;
    logic        reset;
    logic        slot_release;
    logic [4:0]  slots_used;
    logic        irq;
    logic [15:0] drop_count;
    int          cyc;
    int          n_pass;
    int          n_total;

    typedef struct packed {
        logic [13:0] addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    wr_t wlog[$];

    dircc_node_rx_msg_writer_if bus ();

    dircc_node_rx_msg_writer #(
        .BASE_ADDR  (14'h2000),
        .SLOT_WORDS (16),
        .NUM_SLOTS  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .slot_release (slot_release),
        .slots_used   (slots_used),
        .irq          (irq),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory writes are recorded mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (bus.mem_chipselect && bus.mem_write)
            wlog.push_back('{addr: bus.mem_address, data: bus.mem_writedata, cyc: cyc});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [13:0] a, input logic [15:0] d);
        wr_t e;
        e = (idx < wlog.size()) ? wlog[idx] : '0;
        chk(tag, {2'b00, e.addr, e.data}, {2'b00, a, d});
    endtask

    task automatic beat(input logic [15:0] d, input logic s, input logic e);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sop   = s;
        bus.in_eop   = e;
        tick();
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        wlog.delete();
    endtask

    task automatic pulse_release();
        slot_release = 1'b1;
        tick();
        slot_release = 1'b0;
    endtask

    initial begin
        cyc          = 0;
        n_pass       = 0;
        n_total      = 0;
        reset        = 1'b1;
        slot_release = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready",   32'(bus.in_ready), 32'd0);
        chk("rst_cs_we",      {30'd0, bus.mem_chipselect, bus.mem_write}, 32'd0);
        chk("rst_addr",       32'(bus.mem_address), 32'd0);
        chk("rst_wdata",      32'(bus.mem_writedata), 32'd0);
        chk("rst_be_clken",   {29'd0, bus.mem_byteenable, bus.mem_clken}, 32'd7);
        chk("rst_used_irq",   {26'd0, slots_used, irq}, 32'd0);
        chk("rst_drop",       32'(drop_count), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_in_ready",  32'(bus.in_ready), 32'd1);

        // Three-flit message
        wlog.delete();
        beat(16'hA001, 1'b1, 1'b0);
        beat(16'hA002, 1'b0, 1'b0);
        beat(16'hA003, 1'b0, 1'b1);
        chk("hdr_in_ready",   32'(bus.in_ready), 32'd0);
        tick();
        tick();
        chk("m3_nwrites",     32'(wlog.size()), 32'd4);
        chk_wr("m3_w0", 0, 14'h2001, 16'hA001);
        chk_wr("m3_w1", 1, 14'h2002, 16'hA002);
        chk_wr("m3_w2", 2, 14'h2003, 16'hA003);
        chk_wr("m3_hdr", 3, 14'h2000, 16'h0003);
        chk("m3_spacing",     32'(wlog[3].cyc - wlog[0].cyc), 32'd3);
        chk("m3_used_irq",    {26'd0, slots_used, irq}, {26'd1, 1'b1});

        // Twenty-flit message truncated to the slot
        do_reset();
        for (int i = 1; i <= 20; i++)
            beat(16'hB000 + 16'(i), i == 1, i == 20);
        tick();
        tick();
        chk("m20_nwrites",    32'(wlog.size()), 32'd16);
        chk_wr("m20_first", 0, 14'h2001, 16'hB001);
        chk_wr("m20_last", 14, 14'h200F, 16'hB00F);
        chk_wr("m20_hdr", 15, 14'h2000, 16'h8014);

        // Five back-to-back one-flit messages into a four-slot ring
        do_reset();
        for (int i = 0; i < 5; i++) begin
            beat(16'hC000 + 16'(i), 1'b1, 1'b1);
            tick();
        end
        tick();
        tick();
        chk("fill_nwrites",   32'(wlog.size()), 32'd8);
        for (int i = 0; i < 4; i++) begin
            chk_wr("fill_data", 2 * i,     14'h2001 + 14'(16 * i), 16'hC000 + 16'(i));
            chk_wr("fill_hdr",  2 * i + 1, 14'h2000 + 14'(16 * i), 16'h0001);
        end
        chk("fill_used",      32'(slots_used), 32'd4);
        chk("fill_drop",      32'(drop_count), 32'(DC_EN));
        // Multi-flit message dropped while full
        beat(16'hC100, 1'b1, 1'b0);
        beat(16'hC101, 1'b0, 1'b0);
        chk("drop_in_ready",  32'(bus.in_ready), 32'd1);
        beat(16'hC102, 1'b0, 1'b1);
        tick();
        tick();
        chk("drop_nwrites",   32'(wlog.size()), 32'd8);
        chk("drop_count2",    32'(drop_count), 32'(2 * DC_EN));
        chk("drop_used",      32'(slots_used), 32'd4);

        // Release coinciding with a header commit
        do_reset();
        for (int i = 0; i < 2; i++) begin
            beat(16'h5000 + 16'(i), 1'b1, 1'b1);
            tick();
            tick();
        end
        chk("rel_pre_used",   32'(slots_used), 32'd2);
        beat(16'h5002, 1'b1, 1'b1);
        tick();
        slot_release = 1'b1;
        tick();
        slot_release = 1'b0;
        chk("rel_coincide",   32'(slots_used), 32'd2);
        pulse_release();
        pulse_release();
        chk("rel_to_zero",    32'(slots_used), 32'd0);
        pulse_release();
        chk("rel_at_zero",    {26'd0, slots_used, irq}, 32'd0);

        // Reset in the middle of a message
        do_reset();
        beat(16'hD001, 1'b1, 1'b0);
        beat(16'hD002, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        chk("mid_rst_ready",  32'(bus.in_ready), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("mid_rst_nwr",    32'(wlog.size()), 32'd2);
        chk("mid_rst_used",   32'(slots_used), 32'd0);
        beat(16'hE001, 1'b1, 1'b1);
        tick();
        tick();
        chk_wr("post_rst_data", 2, 14'h2001, 16'hE001);
        chk_wr("post_rst_hdr",  3, 14'h2000, 16'h0001);
        chk("post_rst_used",  32'(slots_used), 32'd1);

        // Stray flit without sop in IDLE
        wlog.delete();
        chk("stray_ready",    32'(bus.in_ready), 32'd1);
        beat(16'hF00F, 1'b0, 1'b0);
        tick();
        tick();
        chk("stray_nwrites",  32'(wlog.size()), 32'd0);
        chk("stray_used",     32'(slots_used), 32'd1);
        chk("stray_drop",     32'(drop_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_dircc_node_rx_msg_writer
`default_nettype wire
